// File: rtl/priority_scan_encoder_if.sv
// Handshake bundle for priority_scan_encoder: request-vector input side and index output side.
// The slave modport is the encoder's view; the master modport is the producer/consumer view.
interface priority_scan_encoder_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last
  );
endinterface

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: accepts a request vector and emits one set-bit index per beat in priority order.
// Optional feature macro PRIO_SCAN_CNT_EN adds out_cnt (beats remaining, including the current one).
module priority_scan_encoder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  priority_scan_encoder_if.slave  bus,
  output logic                    zero_flag,
  output logic                    busy
`ifdef PRIO_SCAN_CNT_EN
  ,
  output logic [$clog2(WIDTH):0]  out_cnt
`endif
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t           state_p0, state_d;
  logic [WIDTH-1:0] pend_p0, pend_d;
  logic             zero_p0, zero_d;

  logic [IDX_W-1:0] cur_idx;
  logic             cur_last;
  logic             vld;
  logic             rdy;
  logic             pop;
  logic             accept;

  function automatic logic [IDX_W-1:0] prio_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    // Later hits overwrite earlier ones, so scan toward the priority end.
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (v[i]) idx = i[IDX_W-1:0];
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (v[i]) idx = i[IDX_W-1:0];
    end
    return idx;
  endfunction

  function automatic logic is_single(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] one;
    one = {{(WIDTH-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

  function automatic logic [WIDTH-1:0] bit_mask(input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] one;
    one = {{(WIDTH-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

`ifdef PRIO_SCAN_CNT_EN
  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++)
      cnt = cnt + {{IDX_W{1'b0}}, v[i]};
    return cnt;
  endfunction
`endif

  always_comb begin
    cur_idx  = prio_idx(pend_p0);
    cur_last = is_single(pend_p0);
    vld      = (state_p0 == SCAN) & en & ~rst;
    pop      = vld & bus.out_ready;
    // Ready also on the final pop so consecutive vectors stream without a bubble.
    rdy      = en & ~rst & ((state_p0 == IDLE) | (pop & cur_last));
    accept   = bus.in_valid & rdy;

    state_d  = state_p0;
    pend_d   = pend_p0;
    zero_d   = 1'b0;
    if (accept) begin
      pend_d  = bus.in_vec;
      state_d = (bus.in_vec != '0) ? SCAN : IDLE;
      zero_d  = (bus.in_vec == '0);
    end else if (pop) begin
      pend_d = pend_p0 & ~bit_mask(cur_idx);
      if (cur_last) begin
        state_d = IDLE;
        pend_d  = '0;
      end
    end
  end

  // stage p0: scan state, pending bits, zero-vector pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      pend_p0  <= '0;
      zero_p0  <= 1'b0;
    end else begin
      state_p0 <= state_d;
      pend_p0  <= pend_d;
      zero_p0  <= zero_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_idx   = (state_p0 == SCAN) ? cur_idx : '0;
  assign bus.out_last  = (state_p0 == SCAN) ? cur_last : 1'b0;
  assign zero_flag     = zero_p0 & en;
  assign busy          = (state_p0 == SCAN);

`ifdef PRIO_SCAN_CNT_EN
  assign out_cnt = (state_p0 == SCAN) ? popcount(pend_p0) : '0;
`endif

endmodule
